// File: rtl/rom_loader_if.sv
// Byte stream into the ROM loader.
// Producer drives data/valid, loader drives ready.
interface rom_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/rom_loader.sv
// Hack ROM loader: stream -> 16-bit words -> ROM, holds CPU in reset.
// ROM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module rom_loader #(
  parameter int ADDR_W    = 15,
  parameter int MAX_WORDS = 32768
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  rom_loader_if.slave       s,
  output logic              rom_wr,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_din,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam int CW = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_FINISH,
    S_DONE,
    S_ERROR
`ifdef ROM_LOADER_CHECKSUM_EN
    , S_CKSUM
`endif
  } state_t;

`ifdef ROM_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CKSUM;
`else
  localparam state_t S_TAIL = S_FINISH;
`endif

  state_t          state;
  state_t          state_nx;
  logic [15:0]     len;
  logic [7:0]      hi;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_inc;
  logic [15:0]     n_now;
  logic            loading;
  logic            xfer;
  logic            rearm;
  logic            len_zero;
  logic            len_big;
  logic            last_word;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]      csum;
`endif

  assign loading = state inside {S_LEN_HI, S_LEN_LO,
                                 S_DATA_HI, S_DATA_LO
`ifdef ROM_LOADER_CHECKSUM_EN
                                 , S_CKSUM
`endif
                                 };
  assign s.in_ready = loading & reset;
  assign xfer       = s.in_valid & s.in_ready;
  assign rearm      = start &
                      (state == S_DONE || state == S_ERROR);

  // length low byte is still on the bus when deciding
  assign n_now     = {len[15:8], s.in_data};
  assign len_zero  = n_now == 16'd0;
  assign len_big   = 32'(n_now) > 32'(MAX_WORDS);
  assign cnt_inc   = cnt + CW'(1);
  assign last_word = 32'(cnt_inc) == 32'(len);

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_LEN_HI;
    else        state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      S_LEN_HI:
        if (xfer) state_nx = S_LEN_LO;
      S_LEN_LO:
        if (xfer) begin
          if (len_zero)     state_nx = S_TAIL;
          else if (len_big) state_nx = S_ERROR;
          else              state_nx = S_DATA_HI;
        end
      S_DATA_HI:
        if (xfer) state_nx = S_DATA_LO;
      S_DATA_LO:
        if (xfer) begin
          if (last_word) state_nx = S_TAIL;
          else           state_nx = S_DATA_HI;
        end
      S_FINISH:
        state_nx = S_DONE;
`ifdef ROM_LOADER_CHECKSUM_EN
      S_CKSUM:
        if (xfer) begin
          if (s.in_data == csum) state_nx = S_DONE;
          else                   state_nx = S_ERROR;
        end
`endif
      S_DONE, S_ERROR:
        if (start) state_nx = S_LEN_HI;
      default:
        state_nx = S_LEN_HI;
    endcase
  end

  // byte capture, ROM write port and registered status
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len       <= '0;
      hi        <= '0;
      cnt       <= '0;
      rom_wr    <= 1'b0;
      rom_addr  <= '0;
      rom_din   <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      rom_wr    <= 1'b0;
      done      <= state_nx == S_DONE;
      error     <= state_nx == S_ERROR;
      cpu_reset <= state_nx != S_DONE;
      if (rearm) begin
        cnt      <= '0;
        rom_addr <= '0;
      end
      if (xfer) begin
        unique case (state)
          S_LEN_HI: len[15:8] <= s.in_data;
          S_LEN_LO: begin
            len[7:0] <= s.in_data;
            cnt      <= '0;
          end
          S_DATA_HI: hi <= s.in_data;
          S_DATA_LO: begin
            rom_wr   <= 1'b1;
            rom_addr <= cnt[ADDR_W-1:0];
            rom_din  <= {hi, s.in_data};
            cnt      <= cnt_inc;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  // running XOR of header and data bytes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      csum <= '0;
    else if (rearm)
      csum <= '0;
    else if (xfer && state != S_CKSUM)
      csum <= csum ^ s.in_data;
  end
`endif

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: scoreboard of expected ROM writes.
// Loader built with MAX_WORDS=4 so the length limit is reachable.
module tb_rom_loader;

  localparam int AW = 15;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          rom_wr;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_din;
  logic          cpu_reset;
  logic          done;
  logic          error;

  rom_loader_if m ();

  rom_loader #(
    .ADDR_W(AW),
    .MAX_WORDS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .s(m.slave),
    .rom_wr(rom_wr),
    .rom_addr(rom_addr),
    .rom_din(rom_din),
    .cpu_reset(cpu_reset),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err = 0;
  int          wr_count = 0;
  logic [31:0] sbq[$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // compare every ROM write against the scoreboard
  always @(negedge clk) begin
    if (rom_wr === 1'b1) begin
      wr_count++;
      if (sbq.size() == 0)
        check("wr_unexpected", {1'b0, rom_addr, rom_din}, 32'hFFFF_FFFF);
      else
        check("wr", {1'b0, rom_addr, rom_din}, sbq.pop_front());
    end
  end

  task automatic send(input logic [7:0] b, input bit gaps);
    int k;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    m.in_data  = b;
    m.in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (m.in_ready !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    m.in_valid = 1'b0;
  endtask

  task automatic push_wr(input int a,
                         input logic [7:0] h,
                         input logic [7:0] l);
    sbq.push_back({1'b0, 15'(a), h, l});
  endtask

  task automatic send_image(input bq_t img, input bit gaps);
    logic [7:0] cs;
    int a;
    cs = 8'h00;
    a = 0;
    for (int i = 0; i < img.size(); i++) begin
      cs ^= img[i];
      if (i >= 3 && i % 2 == 1) begin
        push_wr(a, img[i-1], img[i]);
        a++;
      end
      send(img[i], gaps);
    end
`ifdef ROM_LOADER_CHECKSUM_EN
    send(cs, gaps);
`else
    if (cs === 8'hxx) check("cs_x", 0, 1);
`endif
  endtask

  task automatic expect_done(input string tag);
`ifdef ROM_LOADER_CHECKSUM_EN
    @(negedge clk);
`else
    @(negedge clk);
    check({tag, "_done_early"}, done, 0);
    check({tag, "_cpu_hold"}, cpu_reset, 1);
    @(negedge clk);
`endif
    check({tag, "_done"}, done, 1);
    check({tag, "_cpu_rel"}, cpu_reset, 0);
    check({tag, "_rdy"}, m.in_ready, 0);
    check({tag, "_err"}, error, 0);
    check({tag, "_sb"}, sbq.size(), 0);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("rearm_rdy", m.in_ready, 1);
    check("rearm_done", done, 0);
    check("rearm_err", error, 0);
    check("rearm_cpu", cpu_reset, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t img;
    int  snap;
    m.in_data  = 8'h00;
    m.in_valid = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", m.in_ready, 0);
    check("rst_wr", rom_wr, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_din", rom_din, 0);
    check("rst_cpu", cpu_reset, 1);
    check("rst_done", done, 0);
    check("rst_err", error, 0);
    reset = 1'b1;
    #1 check("rel_rdy", m.in_ready, 1);

    // two words, back-to-back
    img = '{8'h00, 8'h02, 8'hEA, 8'h87, 8'h00, 8'h07};
    send_image(img, 1'b0);
    expect_done("two");
    check("two_wrs", wr_count, 2);

    // start ignored while done is low is not exercised;
    // empty image
    pulse_start();
    snap = wr_count;
    img = '{8'h00, 8'h00};
    send_image(img, 1'b0);
    expect_done("empty");
    check("empty_nowr", wr_count, snap);

    // length above the limit
    pulse_start();
    snap = wr_count;
    send(8'h00, 1'b0);
    send(8'h05, 1'b0);
    @(negedge clk);
    check("big_err", error, 1);
    check("big_cpu", cpu_reset, 1);
    check("big_rdy", m.in_ready, 0);
    check("big_done", done, 0);
    m.in_data  = 8'hAA;
    m.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    m.in_valid = 1'b0;
    check("big_err_hold", error, 1);
    check("big_nowr", wr_count, snap);

    // random gaps on a three-word image
    pulse_start();
    snap = wr_count;
    img = '{8'h00, 8'h03, 8'h12, 8'h34,
            8'h56, 8'h78, 8'h9A, 8'hBC};
    send_image(img, 1'b1);
    expect_done("gaps");
    check("gaps_wrs", wr_count, snap + 3);

    // reset in the middle of a load
    pulse_start();
    send(8'h00, 1'b0);
    send(8'h03, 1'b0);
    send(8'h12, 1'b0);
    push_wr(0, 8'h12, 8'h34);
    send(8'h34, 1'b0);
    send(8'h56, 1'b0);
    reset = 1'b0;
    #1;
    check("mid_wr", rom_wr, 0);
    check("mid_addr", rom_addr, 0);
    check("mid_din", rom_din, 0);
    check("mid_cpu", cpu_reset, 1);
    check("mid_rdy", m.in_ready, 0);
    check("mid_done", done, 0);
    check("mid_sb", sbq.size(), 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    snap = wr_count;
    send_image(img, 1'b0);
    expect_done("resend");
    check("resend_wrs", wr_count, snap + 3);

    // exactly the word limit
    pulse_start();
    img = '{8'h00, 8'h04, 8'hFF, 8'hFF, 8'h00, 8'h01,
            8'h80, 8'h00, 8'h7F, 8'hFE};
    send_image(img, 1'b0);
    expect_done("max");

`ifdef ROM_LOADER_CHECKSUM_EN
    pulse_start();
    send(8'h00, 1'b0);
    send(8'h01, 1'b0);
    send(8'hAB, 1'b0);
    push_wr(0, 8'hAB, 8'hCD);
    send(8'hCD, 1'b0);
    send(8'h67, 1'b0);
    @(negedge clk);
    check("ck_ok_done", done, 1);
    check("ck_ok_cpu", cpu_reset, 0);
    pulse_start();
    send(8'h00, 1'b0);
    send(8'h01, 1'b0);
    send(8'hAB, 1'b0);
    push_wr(0, 8'hAB, 8'hCD);
    send(8'hCD, 1'b0);
    send(8'h00, 1'b0);
    @(negedge clk);
    check("ck_bad_err", error, 1);
    check("ck_bad_cpu", cpu_reset, 1);
    check("ck_bad_done", done, 0);
    pulse_start();
    img = '{8'h00, 8'h01, 8'h11, 8'h22};
    send_image(img, 1'b0);
    expect_done("ck_again");
`endif

    repeat (2) @(negedge clk);
    check("sb_drain", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
